write_back_regfile: RTL and testbench
=====================================

Name: write_back_regfile

Overview:
- Write-back stage plus architectural integer register file for the 5-stage RISC-V pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the write-back value: load data or ALU result.
- Commits that value into a 32x32 register file.
- Serves the ID stage's two source-operand read ports, with same-cycle write-to-read bypass.
- Keeps a count of committed register writes for debug and performance visibility.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; register count is 2**ADDR_W.
- BYPASS_EN, 1, 1 = read ports return same-cycle write data on index match; 0 = read ports return stored value only.
- CNT_W, 32, width of the committed-write counter.

Ports:
- sys_clk_i, input, 1, system clock; all state updates on the rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- DM_rd_data_i, input, DATA_W, load data from MEM/WB.
- alu_result_i, input, DATA_W, ALU result from MEM/WB.
- RegWrite_i, input, 1, write enable from MEM/WB.
- MemtoReg_i, input, 1, 1 = write DM_rd_data_i; 0 = write alu_result_i.
- rd_i, input, ADDR_W, destination register index from MEM/WB.
- rs1_i, input, ADDR_W, ID-stage source index 1.
- rs2_i, input, ADDR_W, ID-stage source index 2.
- rs1_data_o, output, DATA_W, operand for rs1_i.
- rs2_data_o, output, DATA_W, operand for rs2_i.
- wb_data_o, output, DATA_W, selected write-back value (combinational), exported for EX forwarding.
- wb_we_o, output, 1, effective write strobe: RegWrite_i and rd_i != 0.
- wb_cnt_o, output, CNT_W, number of committed writes.

Behaviour:
- Interface: one clock, sys_clk_i. Reset rst_i is asynchronous and active-high.
- Reset:
  - All registers x0..x31 clear to 0 immediately on rst_i assertion, independent of the clock.
  - wb_cnt_o clears to 0.
  - While rst_i is high, no write occurs even if RegWrite_i = 1.
  - On deassertion, the first commit can happen at the next rising edge.
- Write-back select: wb_data_o = MemtoReg_i ? DM_rd_data_i : alu_result_i. Pure combinational, zero latency.
- Commit rule: at a rising edge with wb_we_o = 1, reg[rd_i] <= wb_data_o, and wb_cnt_o increments by 1.
- Register x0:
  - Hardwired zero; never written.
  - Reads of index 0 always return 0, including when BYPASS_EN = 1 and rd_i = 0.
  - A write targeting rd = 0 does not increment wb_cnt_o.
- Read ports: combinational, both independent, and both may address the same index.
  - BYPASS_EN = 1: if wb_we_o = 1 and rsN_i == rd_i, then rsN_data_o = wb_data_o (write-first). Otherwise rsN_data_o = reg[rsN_i].
  - BYPASS_EN = 0: rsN_data_o = reg[rsN_i]. The new value becomes visible the cycle after the commit edge.
- Read latency: 0 cycles for stored values. Write-to-read visibility is 0 cycles with bypass, 1 cycle without.
- Bubbles: RegWrite_i = 0 means no commit, no count change, and no bypass.
- Counter: wraps modulo 2**CNT_W; no saturation and no overflow flag.
- Reset mid-operation: a commit in flight at the reset edge is discarded, and outputs show 0 for all indices during reset.
- X-safety: when wb_we_o = 0, rd_i, DM_rd_data_i and alu_result_i are don't-care and must not corrupt state.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN = 32.
  - REG_ADDR_W = 5.
  - REG_ZERO = 5'd0.
  - WB_SEL_ALU = 0 and WB_SEL_MEM = 1, the encodings of MemtoReg.
- Sub-module regfile_2r1w: storage array with async clear, x0 hardwiring, and plain 2-read / 1-write ports.
- Top level adds:
  - the write-back mux,
  - the bypass compare logic,
  - the commit counter.

Test Plan:
- Reset: assert rst_i asynchronously between clock edges with reg x5 = 32'hDEADBEEF -> rs1_data_o for x5 is 0 immediately, before the next edge, and wb_cnt_o = 0.
- ALU and load write-back:
  - RegWrite_i = 1, MemtoReg_i = 0, rd_i = 3, alu_result_i = 32'h0000_1234, then read x3 -> 32'h0000_1234, and wb_cnt_o = 1.
  - Repeat with MemtoReg_i = 1, DM_rd_data_i = 32'hCAFE_F00D, rd_i = 4 -> x4 = 32'hCAFE_F00D, and wb_cnt_o = 2.
- Bypass, BYPASS_EN = 1: in the same cycle, rd_i = 7 writing 32'hA5A5_A5A5 while rs1_i = rs2_i = 7 -> both outputs = 32'hA5A5_A5A5 before the edge.
- No bypass, BYPASS_EN = 0: the same stimulus returns the old value (0) before the edge and 32'hA5A5_A5A5 after it.
- x0 protection: RegWrite_i = 1, rd_i = 0, alu_result_i = 32'hFFFF_FFFF, rs1_i = 0 -> rs1_data_o = 0 before and after the edge, wb_we_o = 0, and wb_cnt_o unchanged.
- Bubble and wrap:
  - RegWrite_i = 0 with rd_i = 9 and garbage data -> x9 unchanged and counter unchanged.
  - With CNT_W = 4, 17 commits -> wb_cnt_o = 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the 5-stage RISC-V pipeline.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Encoding of the MemtoReg control bit
  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: 2 combinational reads, 1 synchronous write,
// asynchronous clear, x0 hardwired to zero.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];

  // Storage: async clear, write only when enabled and not targeting x0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: index 0 always returns zero
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = mem[raddr1];
    if (raddr2 != '0) rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/write_back_regfile.sv
// Write-back stage: result select, register file commit, ID read ports with
// optional same-cycle bypass, and committed-write counter.
module write_back_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_W    = XLEN,
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter bit          BYPASS_EN = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] DM_rd_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_we_o,
  output logic [CNT_W-1:0]  wb_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [CNT_W-1:0]  cnt;

  // Write-back select and effective strobe (x0 writes are not commits)
  always_comb begin
    wb_data_o = (wb_sel_e'(MemtoReg_i) == WB_SEL_MEM) ? DM_rd_data_i : alu_result_i;
    wb_we_o   = RegWrite_i && (rd_i != '0);
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk    (sys_clk_i),
    .rst    (rst_i),
    .we     (wb_we_o),
    .waddr  (rd_i),
    .wdata  (wb_data_o),
    .raddr1 (rs1_i),
    .raddr2 (rs2_i),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Operand read with write-first bypass; suppressed during reset so every
  // index reads zero while rst_i is high
  always_comb begin
    rs1_data_o = rf_rdata1;
    rs2_data_o = rf_rdata2;
    if (BYPASS_EN && wb_we_o && !rst_i) begin
      if (rs1_i == rd_i) rs1_data_o = wb_data_o;
      if (rs2_i == rd_i) rs2_data_o = wb_data_o;
    end
  end

  // Committed-write counter, wraps modulo 2**CNT_W
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (wb_we_o) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign wb_cnt_o = cnt;

endmodule

// File: tb/tb_write_back_regfile.sv
// Directed bench for write_back_regfile: bypass, no-bypass and 4-bit counter
// variants share one stimulus stream.
module tb_write_back_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_data;
  logic [31:0] alu_res;
  logic        reg_write;
  logic        mem_to_reg;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  logic [31:0] a_rs1, a_rs2, a_wb;
  logic        a_we;
  logic [31:0] a_cnt;
  logic [31:0] b_rs1, b_rs2, b_wb;
  logic        b_we;
  logic [31:0] b_cnt;
  logic [31:0] c_rs1, c_rs2, c_wb;
  logic        c_we;
  logic [3:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_back_regfile #(.BYPASS_EN(1'b1)) dut (
    .sys_clk_i(clk), .rst_i(rst), .DM_rd_data_i(dm_data), .alu_result_i(alu_res),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_data_o(a_rs1), .rs2_data_o(a_rs2), .wb_data_o(a_wb), .wb_we_o(a_we), .wb_cnt_o(a_cnt)
  );

  write_back_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .sys_clk_i(clk), .rst_i(rst), .DM_rd_data_i(dm_data), .alu_result_i(alu_res),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_data_o(b_rs1), .rs2_data_o(b_rs2), .wb_data_o(b_wb), .wb_we_o(b_we), .wb_cnt_o(b_cnt)
  );

  write_back_regfile #(.CNT_W(4)) dut_c4 (
    .sys_clk_i(clk), .rst_i(rst), .DM_rd_data_i(dm_data), .alu_result_i(alu_res),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_data_o(c_rs1), .rs2_data_o(c_rs2), .wb_data_o(c_wb), .wb_we_o(c_we), .wb_cnt_o(c_cnt)
  );

  // Advance to 1 ns past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    rd         = 5'd0;
    dm_data    = 32'h0;
    alu_res    = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs1 = 5'd0;
    rs2 = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (a_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp %h", a_cnt, 32'd0); end
    // load x5 = DEADBEEF
    reg_write = 1'b1; rd = 5'd5; alu_res = 32'hDEADBEEF; rs1 = 5'd5;
    tick();
    idle();
    #1;
    checks++;
    if (a_rs1 !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_loaded got %h exp %h", a_rs1, 32'hDEADBEEF); end
    // async reset between edges with a commit pending
    reg_write = 1'b1; rd = 5'd5; alu_res = 32'h1111_2222;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (a_rs1 !== 32'h0) begin errors++; $display("FAIL async_clear_x5 got %h exp %h", a_rs1, 32'h0); end
    checks++;
    if (b_rs1 !== 32'h0) begin errors++; $display("FAIL async_clear_x5_nb got %h exp %h", b_rs1, 32'h0); end
    checks++;
    if (a_cnt !== 32'd0) begin errors++; $display("FAIL async_clear_cnt got %h exp %h", a_cnt, 32'd0); end
    // edge while reset is high must not commit
    tick();
    checks++;
    if (a_rs1 !== 32'h0 || b_rs1 !== 32'h0 || a_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_blocks_write got %h/%h cnt %h exp 0/0 cnt 0", a_rs1, b_rs1, a_cnt);
    end
    idle();
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_load();
    reg_write = 1'b1; mem_to_reg = 1'b0; rd = 5'd3; alu_res = 32'h0000_1234;
    dm_data = 32'h5555_5555; rs1 = 5'd1; rs2 = 5'd2;
    #1;
    checks++;
    if (a_wb !== 32'h0000_1234) begin errors++; $display("FAIL wb_sel_alu got %h exp %h", a_wb, 32'h0000_1234); end
    tick();
    idle();
    rs1 = 5'd3;
    #1;
    checks++;
    if (a_rs1 !== 32'h0000_1234 || a_cnt !== 32'd1) begin
      errors++; $display("FAIL alu_commit got %h cnt %0d exp %h cnt 1", a_rs1, a_cnt, 32'h0000_1234);
    end
    reg_write = 1'b1; mem_to_reg = 1'b1; rd = 5'd4; dm_data = 32'hCAFE_F00D; alu_res = 32'h7777_7777;
    #1;
    checks++;
    if (a_wb !== 32'hCAFE_F00D) begin errors++; $display("FAIL wb_sel_mem got %h exp %h", a_wb, 32'hCAFE_F00D); end
    tick();
    idle();
    rs2 = 5'd4;
    #1;
    checks++;
    if (a_rs2 !== 32'hCAFE_F00D || a_rs1 !== 32'h0000_1234 || a_cnt !== 32'd2) begin
      errors++; $display("FAIL load_commit got x4 %h x3 %h cnt %0d exp %h %h 2", a_rs2, a_rs1, a_cnt, 32'hCAFE_F00D, 32'h0000_1234);
    end
  endtask

  task automatic test_bypass();
    reg_write = 1'b1; mem_to_reg = 1'b0; rd = 5'd7; alu_res = 32'hA5A5_A5A5; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    checks++;
    if (a_rs1 !== 32'hA5A5_A5A5 || a_rs2 !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL bypass_same_cycle got %h %h exp %h", a_rs1, a_rs2, 32'hA5A5_A5A5);
    end
    checks++;
    if (b_rs1 !== 32'h0 || b_rs2 !== 32'h0) begin
      errors++; $display("FAIL nobypass_before got %h %h exp 0", b_rs1, b_rs2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (b_rs1 !== 32'hA5A5_A5A5 || b_rs2 !== 32'hA5A5_A5A5 || b_cnt !== 32'd3) begin
      errors++; $display("FAIL nobypass_after got %h %h cnt %0d exp %h cnt 3", b_rs1, b_rs2, b_cnt, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_x0();
    reg_write = 1'b1; mem_to_reg = 1'b0; rd = 5'd0; alu_res = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    checks++;
    if (a_we !== 1'b0 || a_rs1 !== 32'h0 || a_rs2 !== 32'h0) begin
      errors++; $display("FAIL x0_before got we %b rs1 %h rs2 %h exp 0 0 0", a_we, a_rs1, a_rs2);
    end
    tick();
    #1;
    checks++;
    if (a_rs1 !== 32'h0 || b_rs1 !== 32'h0 || a_cnt !== 32'd3) begin
      errors++; $display("FAIL x0_after got %h %h cnt %0d exp 0 0 3", a_rs1, b_rs1, a_cnt);
    end
    idle();
  endtask

  task automatic test_bubble();
    reg_write = 1'b0; mem_to_reg = 1'b1; rd = 5'd9; dm_data = 32'hBAD0_BAD0; alu_res = 32'h0BAD_0BAD;
    rs1 = 5'd9; rs2 = 5'd3;
    #1;
    checks++;
    if (a_we !== 1'b0 || a_rs1 !== 32'h0) begin
      errors++; $display("FAIL bubble_before got we %b rs1 %h exp 0 0", a_we, a_rs1);
    end
    tick();
    #1;
    checks++;
    if (a_rs1 !== 32'h0 || a_rs2 !== 32'h0000_1234 || a_cnt !== 32'd3) begin
      errors++; $display("FAIL bubble_after got x9 %h x3 %h cnt %0d exp 0 %h 3", a_rs1, a_rs2, a_cnt, 32'h0000_1234);
    end
    idle();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      reg_write = 1'b1; mem_to_reg = 1'b0;
      rd = 5'(i); alu_res = 32'(i) * 32'h0101;
      tick();
    end
    idle();
    rs1 = 5'd17; rs2 = 5'd16;
    #1;
    checks++;
    if (c_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got %0d exp 1", c_cnt); end
    checks++;
    if (a_cnt !== 32'd17) begin errors++; $display("FAIL cnt32_17 got %0d exp 17", a_cnt); end
    checks++;
    if (a_rs1 !== 32'h0000_1111 || a_rs2 !== 32'h0000_1010) begin
      errors++; $display("FAIL back_to_back got %h %h exp %h %h", a_rs1, a_rs2, 32'h0000_1111, 32'h0000_1010);
    end
  endtask

  initial begin
    rst = 1'b1;
    rs1 = 5'd0;
    rs2 = 5'd0;
    idle();
    test_reset();
    test_alu_load();
    test_bypass();
    test_x0();
    test_bubble();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
